// File: rtl/blit_pkg.sv
// Shared constants and types for the sprite blitter.
package blit_pkg;

    localparam logic [1:0] MODE_OPAQUE = 2'b00;
    localparam logic [1:0] MODE_KEY    = 2'b01;
    localparam logic [1:0] MODE_FILL   = 2'b10;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

    localparam logic [2:0] BLACK = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } blit_state_t;

    // Counter width able to hold 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/blit_raster_counter.sv
// Row-major raster position generator: sprite column, row and linear ROM
// address, advanced together. The address is incremented, never multiplied.
module blit_raster_counter
    import blit_pkg::*;
#(
    parameter int SPR_W  = 160,
    parameter int SPR_H  = 120,
    parameter int ADDR_W = 15,
    localparam int SX_W  = cnt_width(SPR_W),
    localparam int SY_W  = cnt_width(SPR_H)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic              advance,
    output logic [SX_W-1:0]   sx,
    output logic [SY_W-1:0]   sy,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic row_end;

    // Decode end of row and final pixel of the sprite.
    always_comb begin
        row_end = (sx == SX_W'(SPR_W - 1));
        last    = row_end && (sy == SY_W'(SPR_H - 1));
    end

    // Raster walk: column wraps into the next row, address tracks linearly.
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            sx   <= '0;
            sy   <= '0;
            addr <= '0;
        end else if (advance) begin
            if (row_end) begin
                sx <= '0;
                sy <= sy + 1'b1;
            end else begin
                sx <= sx + 1'b1;
            end
            addr <= addr + 1'b1;
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: streams a SPR_W x SPR_H image out of a synchronous colour
// ROM onto the VGA plot interface at a latched origin, with clipping,
// colour-key transparency and solid-fill modes.
module sprite_blitter
    import blit_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int SPR_W    = 160,
    parameter int SPR_H    = 120,
    parameter int ADDR_W   = 15,
    parameter int ROM_LAT  = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [X_W-1:0]      x_origin,
    input  logic [Y_W-1:0]      y_origin,
    input  logic [1:0]          mode,
    input  logic [COLOUR_W-1:0] key_colour,
    input  logic [COLOUR_W-1:0] fill_colour,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_q,
    output logic [X_W-1:0]      x_to_vga,
    output logic [Y_W-1:0]      y_to_vga,
    output logic [COLOUR_W-1:0] colour_to_vga,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    localparam int SX_W = cnt_width(SPR_W);
    localparam int SY_W = cnt_width(SPR_H);
    localparam int XS_W = X_W + 1;
    localparam int YS_W = Y_W + 1;
    localparam int DC_W = cnt_width(ROM_LAT + 1);

    blit_state_t state, state_next;

    logic                accept;
    logic                advance;
    logic                last;
    logic [SX_W-1:0]     sx;
    logic [SY_W-1:0]     sy;
    logic [DC_W-1:0]     drain_cnt;

    logic [X_W-1:0]      x_org;
    logic [Y_W-1:0]      y_org;
    logic [1:0]          mode_r;
    logic [COLOUR_W-1:0] key_r;
    logic [COLOUR_W-1:0] fill_r;

    logic                pv  [ROM_LAT];
    logic [SX_W-1:0]     psx [ROM_LAT];
    logic [SY_W-1:0]     psy [ROM_LAT];

    logic [XS_W-1:0]     sum_x;
    logic [YS_W-1:0]     sum_y;
    logic                draw;
    logic [COLOUR_W-1:0] pix_colour;

    blit_raster_counter #(
        .SPR_W  (SPR_W),
        .SPR_H  (SPR_H),
        .ADDR_W (ADDR_W)
    ) u_raster (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (accept),
        .advance (advance),
        .sx      (sx),
        .sy      (sy),
        .addr    (rom_addr),
        .last    (last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_next;
    end

    // Next-state and control decode.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        advance    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                busy = 1'b1;
                if (last) state_next = ST_DRAIN;
                else      advance    = 1'b1;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == DC_W'(ROM_LAT)) state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Drain timer: counts the ROM_LAT+1 cycles spent flushing the pipeline.
    always_ff @(posedge clk) begin
        if (!resetn || state != ST_DRAIN) drain_cnt <= '0;
        else                              drain_cnt <= drain_cnt + 1'b1;
    end

    // Configuration captured when a start is accepted.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_org  <= '0;
            y_org  <= '0;
            mode_r <= MODE_OPAQUE;
            key_r  <= '0;
            fill_r <= '0;
        end else if (accept) begin
            x_org  <= x_origin;
            y_org  <= y_origin;
            mode_r <= mode;
            key_r  <= key_colour;
            fill_r <= fill_colour;
        end
    end

    // Delay line keeping position and valid aligned with the ROM read data.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < ROM_LAT; i++) begin
                pv[i]  <= 1'b0;
                psx[i] <= '0;
                psy[i] <= '0;
            end
        end else begin
            pv[0]  <= (state == ST_SCAN);
            psx[0] <= sx;
            psy[0] <= sy;
            for (int unsigned i = 1; i < ROM_LAT; i++) begin
                pv[i]  <= pv[i-1];
                psx[i] <= psx[i-1];
                psy[i] <= psy[i-1];
            end
        end
    end

    // Screen position, clip, key and fill decode for the pixel now on rom_q.
    always_comb begin
        sum_x      = XS_W'(x_org) + XS_W'(psx[ROM_LAT-1]);
        sum_y      = YS_W'(y_org) + YS_W'(psy[ROM_LAT-1]);
        pix_colour = (mode_r == MODE_FILL) ? fill_r : rom_q;
        draw       = pv[ROM_LAT-1]
                     && (sum_x < XS_W'(SCREEN_W))
                     && (sum_y < YS_W'(SCREEN_H))
                     && !((mode_r == MODE_KEY) && (rom_q == key_r));
    end

    // Output register; coordinates and colour only move on a plotted pixel.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            plot          <= 1'b0;
            x_to_vga      <= '0;
            y_to_vga      <= '0;
            colour_to_vga <= COLOUR_W'(BLACK);
        end else begin
            plot <= draw;
            if (draw) begin
                x_to_vga      <= sum_x[X_W-1:0];
                y_to_vga      <= sum_y[Y_W-1:0];
                colour_to_vga <= pix_colour;
            end
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: a full-screen instance (ROM_LAT=1) and a 4x2
// instance (ROM_LAT=3), each with a behavioural ROM, checked cycle by cycle
// against a scoreboard of expected plots and handshake timing.
module tb_sprite_blitter;
    import blit_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn = 1'b0;
    logic       start  = 1'b0;
    logic       sel    = 1'b0;
    logic [7:0] x_origin = '0;
    logic [6:0] y_origin = '0;
    logic [1:0] mode = '0;
    logic [2:0] key_colour = '0;
    logic [2:0] fill_colour = '0;
    int         pat = 0;

    logic f_start, s_start;
    assign f_start = start & ~sel;
    assign s_start = start & sel;

    logic [14:0] f_addr;
    logic [2:0]  f_q, f_c;
    logic [7:0]  f_x;
    logic [6:0]  f_y;
    logic        f_plot, f_busy, f_done;

    logic [2:0]  s_addr;
    logic [2:0]  s_q, s_c;
    logic [7:0]  s_x;
    logic [6:0]  s_y;
    logic        s_plot, s_busy, s_done;

    sprite_blitter #(
        .SCREEN_W(160), .SCREEN_H(120), .X_W(8), .Y_W(7), .COLOUR_W(3),
        .SPR_W(160), .SPR_H(120), .ADDR_W(15), .ROM_LAT(1)
    ) u_full (
        .clk(clk), .resetn(resetn), .start(f_start),
        .x_origin(x_origin), .y_origin(y_origin), .mode(mode),
        .key_colour(key_colour), .fill_colour(fill_colour),
        .rom_addr(f_addr), .rom_q(f_q),
        .x_to_vga(f_x), .y_to_vga(f_y), .colour_to_vga(f_c),
        .plot(f_plot), .busy(f_busy), .done(f_done)
    );

    sprite_blitter #(
        .SCREEN_W(160), .SCREEN_H(120), .X_W(8), .Y_W(7), .COLOUR_W(3),
        .SPR_W(4), .SPR_H(2), .ADDR_W(3), .ROM_LAT(3)
    ) u_small (
        .clk(clk), .resetn(resetn), .start(s_start),
        .x_origin(x_origin), .y_origin(y_origin), .mode(mode),
        .key_colour(key_colour), .fill_colour(fill_colour),
        .rom_addr(s_addr), .rom_q(s_q),
        .x_to_vga(s_x), .y_to_vga(s_y), .colour_to_vga(s_c),
        .plot(s_plot), .busy(s_busy), .done(s_done)
    );

    // ROM contents: 0 -> addr[2:0], 1 -> alternating 0/5, else scrambled.
    function automatic logic [2:0] romf(input int p, input int a);
        case (p)
            0:       return 3'(a);
            1:       return (a % 2 == 1) ? 3'd5 : 3'd0;
            default: return 3'(a * 3 + 1);
        endcase
    endfunction

    logic [14:0] f_ad;
    logic [2:0]  s_ad0, s_ad1, s_ad2;
    always @(posedge clk) begin
        f_ad  <= f_addr;
        s_ad0 <= s_addr;
        s_ad1 <= s_ad0;
        s_ad2 <= s_ad1;
    end
    assign f_q = romf(pat, int'(f_ad));
    assign s_q = romf(pat, int'(s_ad2));

    logic [14:0] m_addr;
    logic [7:0]  m_x;
    logic [6:0]  m_y;
    logic [2:0]  m_c;
    logic        m_plot, m_busy, m_done;
    always_comb begin
        m_addr = sel ? 15'(s_addr) : f_addr;
        m_x    = sel ? s_x : f_x;
        m_y    = sel ? s_y : f_y;
        m_c    = sel ? s_c : f_c;
        m_plot = sel ? s_plot : f_plot;
        m_busy = sel ? s_busy : f_busy;
        m_done = sel ? s_done : f_done;
    end

    typedef struct { int x; int y; int c; int at; } pix_t;
    typedef struct {
        bit sel; int x0; int y0; int mode; int key; int fill; int pat;
        int g; int n_plot;
    } vec_t;

    pix_t sbq[$];
    int   cyc = 0;
    logic rst_q = 1'b0;
    bit   mon_en = 1'b0;
    bit   active = 1'b0;
    int   E = 0, N = 1, L = 1, plots = 0;
    int   hold_addr[2], lx[2], ly[2], lc[2];
    int   errors = 0, checks = 0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= !resetn;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Cycle monitor: cycle index is the number of rising edges so far.
    always @(negedge clk) begin
        int   s;
        int   ea;
        bit   ep;
        pix_t p;
        if (mon_en) begin
            s = int'(sel);
            if (rst_q) begin
                active = 1'b0;
                sbq.delete();
                for (int i = 0; i < 2; i++) begin
                    hold_addr[i] = 0; lx[i] = 0; ly[i] = 0; lc[i] = 0;
                end
                chk("rst_plot", int'(m_plot), 0);
                chk("rst_busy", int'(m_busy), 0);
                chk("rst_done", int'(m_done), 0);
                chk("rst_addr", int'(m_addr), 0);
                chk("rst_x", int'(m_x), 0);
                chk("rst_y", int'(m_y), 0);
                chk("rst_colour", int'(m_c), 0);
            end else begin
                ea = hold_addr[s];
                if (active && cyc >= E) ea = (cyc - E < N) ? cyc - E : N - 1;
                chk("rom_addr", int'(m_addr), ea);
                chk("busy", int'(m_busy), int'(active && cyc >= E && cyc <= E + N + L));
                chk("done", int'(m_done), int'(active && cyc == E + N + L + 1));
                ep = (sbq.size() > 0) && (sbq[0].at == cyc);
                chk("plot", int'(m_plot), int'(ep));
                if (ep) begin
                    p = sbq.pop_front();
                    lx[s] = p.x; ly[s] = p.y; lc[s] = p.c;
                    plots++;
                end
                chk("x_to_vga", int'(m_x), lx[s]);
                chk("y_to_vga", int'(m_y), ly[s]);
                chk("colour_to_vga", int'(m_c), lc[s]);
                if (active && cyc == E + N + L + 1) begin
                    active = 1'b0;
                    hold_addr[s] = N - 1;
                end
            end
        end
    end

    // Drive a start and load the scoreboard with the expected plots.
    task automatic launch(input vec_t v);
        int sw, xs, ys, col;
        bit pl;
        @(posedge clk);
        #1;
        sel = v.sel;
        pat = v.pat;
        @(negedge clk);
        x_origin    = 8'(v.x0);
        y_origin    = 7'(v.y0);
        mode        = 2'(v.mode);
        key_colour  = 3'(v.key);
        fill_colour = 3'(v.fill);
        start       = 1'b1;
        sw = v.sel ? 4 : 160;
        N  = v.sel ? 8 : 19200;
        L  = v.sel ? 3 : 1;
        E  = cyc + 1;
        plots = 0;
        for (int n = 0; n < N; n++) begin
            xs  = v.x0 + n % sw;
            ys  = v.y0 + n / sw;
            col = int'(romf(v.pat, n));
            pl  = (xs < 160) && (ys < 120) && !(v.mode == 1 && col == v.key);
            if (v.mode == 2) col = v.fill;
            if (pl) sbq.push_back('{x: xs, y: ys, c: col, at: E + 1 + n + L});
        end
        active = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Full blit; optional one-cycle start glitch g cycles after acceptance.
    task automatic run_blit(input vec_t v);
        launch(v);
        for (int c = 0; c < N + L + 6; c++) begin
            start = (v.g >= 0) && (cyc - E == v.g);
            @(negedge clk);
        end
        start = 1'b0;
        if (active) begin
            chk("done_timeout", 0, 1);
            active = 1'b0;
        end
        chk("plot_count", plots, v.n_plot);
        chk("queue_empty", sbq.size(), 0);
    endtask

    vec_t tbl[8];
    vec_t rv;

    initial begin
        //          sel x0   y0   mode key fill pat g   n_plot
        tbl[0] = '{1'b0,   0,   0, 0, 0, 0, 0, -1, 19200};
        tbl[1] = '{1'b1,  10,   5, 0, 0, 0, 2,  3,     8};
        tbl[2] = '{1'b1, 158, 119, 0, 0, 0, 0,  9,     2};
        tbl[3] = '{1'b1,  20,  30, 1, 0, 0, 1, 12,     4};
        tbl[4] = '{1'b1,  40,  50, 2, 0, 4, 0, -1,     8};
        tbl[5] = '{1'b1, 100, 100, 3, 0, 0, 2, -1,     8};
        tbl[6] = '{1'b1, 157, 118, 1, 3, 0, 2, -1,     5};
        tbl[7] = '{1'b0, 100,  60, 1, 2, 0, 0, -1,  3120};

        resetn = 1'b0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) run_blit(tbl[i]);

        // Reset in the middle of a scan abandons the blit without done.
        rv = '{1'b1, 30, 40, 0, 0, 0, 0, -1, 8};
        launch(rv);
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (15) @(negedge clk);
        chk("post_reset_queue", sbq.size(), 0);
        run_blit(rv);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Parametrised raster blitter that copies a SPR_W x SPR_H image from a synchronous colour ROM onto the VGA plot interface at a run-time origin.
- Successor to the fixed full-screen draw blocks. Adds a start/done handshake, origin offset, screen clipping, transparent-key and solid-fill modes, and ROM latency compensation.
- Sits between the game control FSM and the VGA adapter. Owns the ROM address bus while busy.

Parameters:
- SCREEN_W, 160, visible columns
- SCREEN_H, 120, visible rows
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- COLOUR_W, 3, colour bits per pixel
- SPR_W, 160, sprite width in pixels (>=1)
- SPR_H, 120, sprite height in pixels (>=1)
- ADDR_W, 15, ROM address width; must satisfy 2^ADDR_W >= SPR_W*SPR_H
- ROM_LAT, 1, ROM read latency in cycles (>=1)

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- start  in  1  begin blit; sampled only in IDLE
- x_origin  in  X_W  screen x of sprite pixel (0,0); latched on start
- y_origin  in  Y_W  screen y of sprite pixel (0,0); latched on start
- mode  in  2  00 opaque, 01 transparent-key, 10 solid fill, 11 treated as opaque; latched on start
- key_colour  in  COLOUR_W  transparent colour for mode 01; latched on start
- fill_colour  in  COLOUR_W  colour for mode 10; latched on start
- rom_addr  out  ADDR_W  sprite ROM address, row-major
- rom_q  in  COLOUR_W  ROM data, valid ROM_LAT cycles after rom_addr
- x_to_vga  out  X_W  pixel x, registered
- y_to_vga  out  Y_W  pixel y, registered
- colour_to_vga  out  COLOUR_W  pixel colour, registered
- plot  out  1  write enable to VGA adapter
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset is synchronous and active-low (resetn), on clock clk.
- Reset values: all outputs 0. FSM goes to IDLE. Counters and pipeline valids are cleared.
- Reset mid-blit: return to IDLE on the next edge, no done pulse, plot low.
- FSM states: IDLE -> SCAN -> DRAIN -> DONE -> IDLE.
- IDLE: when start=1 at edge k, latch all configuration inputs, clear counters (sx=0, sy=0, addr=0), go to SCAN.
- start while busy or in DONE is ignored.
- SCAN: one address per cycle. Pixel n is issued in cycle k+1+n, with N=SPR_W*SPR_H.
  - sx wraps at SPR_W-1 and increments sy.
  - addr increments by 1. It is computed incrementally; no multiplier.
  - After pixel N-1, go to DRAIN.
- DRAIN: lasts ROM_LAT+1 cycles, then DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Pipeline: sx, sy and valid are delayed ROM_LAT stages alongside the ROM. The output register adds one stage.
  - Pixel n appears on outputs in cycle k+2+n+ROM_LAT.
  - The last plot occurs in cycle k+N+1+ROM_LAT.
  - done occurs in cycle k+N+2+ROM_LAT.
- Clipping: screen coordinates are sums computed in X_W+1 and Y_W+1 bits. Any pixel with sum >= SCREEN_W or >= SCREEN_H gets plot=0.
- Transparency: mode 01 with rom_q==key_colour gives plot=0.
- Fill: mode 10 drives colour_to_vga=fill_colour and ignores rom_q. rom_addr still sequences.
- When plot=0, x_to_vga, y_to_vga and colour_to_vga hold their previous values.
- rom_addr holds its last value outside SCAN.

Decomposition:
- Package blit_pkg holds:
  - mode constants MODE_OPAQUE=2'b00, MODE_KEY=2'b01, MODE_FILL=2'b10;
  - default screen geometry constants (160, 120);
  - colour constant BLACK=3'b000.
- Sub-module blit_raster_counter (sx, sy, addr incremental raster generator with last-pixel flag), parametrised by SPR_W, SPR_H, ADDR_W.

Test Plan:
- Full-screen opaque draw (defaults, origin 0,0, ROM_LAT=1), with ROM pattern colour=addr[2:0] and start at edge k -> 19200 plots, each (x,y) appears exactly once with colour (160y+x)&7; done in cycle k+19203; busy low afterwards.
- SPR_W=4, SPR_H=2, origin (10,5), opaque -> plots at (10..13,5) then (10..13,6) in consecutive cycles; rom_addr 0..7; done one cycle after last plot.
- Clipping: SPR 4x2 at origin (158,119) -> only (158,119) and (159,119) plotted; the other 6 pixels have plot=0; done timing unchanged.
- Transparent key: mode 01, key=3'b000, ROM alternating 0/5 -> plot only on colour-5 pixels; x/y hold on skipped cycles.
- Fill plus latency: mode 10, fill=3'b100, ROM_LAT=3 -> all pixels colour 4 regardless of rom_q; first plot at k+5.
- Robustness: start pulsed mid-SCAN is ignored. resetn low mid-SCAN gives plot=0, busy=0, no done; a subsequent start completes a normal blit.
